writeback_txq: RTL and testbench

- Writeback-stage output block: selects memory or ALU data for register writeback.
- On an OUT instruction, enqueues 1 byte (narrow) or 4 bytes (wide, little-endian) of the writeback value into a parametrised FIFO.
- The FIFO drains through a built-in 8N1 UART serializer on txd.
- Adds over the previous generation: back-pressure (stall), sticky overflow flag, occupancy count and wide mode.

---
 rtl/writeback_txq.sv | 183 ++++++++++++++++++
 tb/tb_writeback_txq.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_txq.sv
// writeback_txq
//   Writeback-stage output block. Selects the register writeback value from
//   memory or ALU data. On an OUT instruction it queues either the low byte
//   or all four bytes (little-endian) of that value into a byte FIFO. The
//   FIFO drains through an 8N1 UART transmitter.
//
// Ports
//   clk        clock
//   rstn       synchronous active-low reset
//   out_valid  OUT instruction in writeback this cycle
//   out_wide   1: queue all 4 bytes of dtowrite, 0: queue dtowrite[7:0]
//   memtoreg   1: writeback value from douta, 0: from d
//   douta      memory read data
//   d          ALU / forwarded data
//   dtowrite   writeback value (combinational)
//   stall      fewer than 4 free FIFO slots; pipeline must hold OUT
//   overflow   sticky: an enqueue request was dropped
//   count      FIFO occupancy
//   txd        UART serial output, idle high
module writeback_txq #(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int DEPTH_LOG2       = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  out_valid,
  input  logic                  out_wide,
  input  logic                  memtoreg,
  input  logic [31:0]           douta,
  input  logic [31:0]           d,
  output logic [31:0]           dtowrite,
  output logic                  stall,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  txd
);

  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int BIT_CYCLES = 2 * CLK_PER_HALF_BIT;
  localparam int BAUD_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [BAUD_W-1:0]     BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   ONE_CNT   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   FOUR_CNT  = (DEPTH_LOG2 + 1)'(4);
  localparam logic [DEPTH_LOG2-1:0] ONE_PTR   = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] head;
  logic [DEPTH_LOG2-1:0] tail;
  logic [DEPTH_LOG2:0]   free_slots;
  logic [DEPTH_LOG2:0]   req_size;
  logic [DEPTH_LOG2:0]   enq_amt;
  logic [DEPTH_LOG2:0]   pop_amt;
  logic                  accept;
  logic                  drop;
  logic                  pop;

  tx_state_t             state;
  logic [BAUD_W-1:0]     baud;
  logic [2:0]            bit_idx;
  logic [7:0]            shift;

  assign dtowrite = memtoreg ? douta : d;

  // Admission is all-or-nothing against the registered occupancy, so a wide
  // request never lands partially.
  assign free_slots = DEPTH_CNT - count;
  assign req_size   = out_wide ? FOUR_CNT : ONE_CNT;
  assign accept     = out_valid && (free_slots >= req_size);
  assign drop       = out_valid && !accept;
  assign stall      = free_slots < FOUR_CNT;

  // Popping only from a registered non-zero count means a byte written into
  // an empty FIFO is sent no earlier than the following cycle.
  assign pop     = (state == IDLE) && (count != '0);
  assign enq_amt = accept ? req_size : '0;
  assign pop_amt = pop ? ONE_CNT : '0;

  // Byte storage; a wide write fills four consecutive slots at once.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[tail] <= dtowrite[7:0];
      if (out_wide) begin
        mem[tail + ONE_PTR]           <= dtowrite[15:8];
        mem[tail + DEPTH_LOG2'(2)]    <= dtowrite[23:16];
        mem[tail + DEPTH_LOG2'(3)]    <= dtowrite[31:24];
      end
    end
  end

  // Pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        tail <= tail + req_size[DEPTH_LOG2-1:0];
      end
      if (pop) begin
        head <= head + ONE_PTR;
      end
      count <= count + enq_amt - pop_amt;
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // 8N1 transmitter. txd is registered so a pop at one edge drives the start
  // bit from the next cycle; the single IDLE cycle after STOP is the one
  // idle-high cycle between back-to-back frames.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shift <= mem[head];
            baud  <= '0;
            state <= START;
            txd   <= 1'b0;
          end
        end
        START: begin
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
            txd     <= shift[0];
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              txd     <= shift[1];
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            state <= IDLE;
            txd   <= 1'b1;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_txq.sv
// tb_writeback_txq
//   Directed bench for writeback_txq with 4 clk cycles per UART bit. Two
//   instances share the stimulus: a 16-byte FIFO (_b) for the main scenarios
//   and a 4-byte FIFO (_s) for full, overflow and pointer-wrap scenarios.
//   Inputs change on the falling edge; outputs are observed on the falling
//   edge, i.e. half a cycle after the rising edge that updated them.
module tb_writeback_txq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        out_valid;
  logic        out_wide;
  logic        memtoreg;
  logic [31:0] douta;
  logic [31:0] d;

  logic [31:0] dtowrite_b;
  logic        stall_b;
  logic        overflow_b;
  logic [4:0]  count_b;
  logic        txd_b;

  logic [31:0] dtowrite_s;
  logic        stall_s;
  logic        overflow_s;
  logic [2:0]  count_s;
  logic        txd_s;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  // Free-running cycle count used to measure frame spacing.
  always @(posedge clk) cyc <= cyc + 1;

  writeback_txq #(.CLK_PER_HALF_BIT(2), .DEPTH_LOG2(4)) dut_b (
    .clk(clk), .rstn(rstn), .out_valid(out_valid), .out_wide(out_wide),
    .memtoreg(memtoreg), .douta(douta), .d(d), .dtowrite(dtowrite_b),
    .stall(stall_b), .overflow(overflow_b), .count(count_b), .txd(txd_b)
  );

  writeback_txq #(.CLK_PER_HALF_BIT(2), .DEPTH_LOG2(2)) dut_s (
    .clk(clk), .rstn(rstn), .out_valid(out_valid), .out_wide(out_wide),
    .memtoreg(memtoreg), .douta(douta), .d(d), .dtowrite(dtowrite_s),
    .stall(stall_s), .overflow(overflow_s), .count(count_s), .txd(txd_s)
  );

  // Drives all enqueue-related inputs at once.
  task automatic applyStimulus(input logic v, input logic w, input logic m,
                               input logic [31:0] da, input logic [31:0] dd);
    out_valid = v;
    out_wide  = w;
    memtoreg  = m;
    douta     = da;
    d         = dd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Captures one UART frame: waits (bounded) for a low txd, then samples the
  // middle of each data bit and of the stop bit. Leaves the caller inside
  // the stop bit so back-to-back frames are caught.
  task automatic get_frame(input int sel, output logic [7:0] data,
                           output int start_cyc, output bit ok);
    int waited = 0;
    ok = 1'b1;
    data = 8'h00;
    start_cyc = 0;
    while (((sel != 0) ? txd_s : txd_b) !== 1'b0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 300) begin
      ok = 1'b0;
      return;
    end
    start_cyc = cyc;
    repeat (5) @(negedge clk);
    data[0] = (sel != 0) ? txd_s : txd_b;
    for (int i = 1; i < 8; i++) begin
      repeat (4) @(negedge clk);
      data[i] = (sel != 0) ? txd_s : txd_b;
    end
    repeat (4) @(negedge clk);
    if (((sel != 0) ? txd_s : txd_b) !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (txd_b !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_txd: got %b expected 1", txd_b);
    end
    checks++;
    if (count_b !== 5'd0) begin
      errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count_b);
    end
    checks++;
    if (overflow_b !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow_b);
    end
    checks++;
    if (stall_b !== 1'b0 || stall_s !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_stall: got %b/%b expected 0/0", stall_b, stall_s);
    end
  endtask

  task automatic test_narrow();
    logic [39:0] cap;
    do_reset();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h00000041);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (count_b !== 5'd1 || txd_b !== 1'b1) begin
      errors++; $display("[TB] FAIL narrow_enq: count=%0d txd=%b expected count=1 txd=1", count_b, txd_b);
    end
    @(negedge clk);
    checks++;
    if (count_b !== 5'd0) begin
      errors++; $display("[TB] FAIL narrow_pop: count=%0d expected 0", count_b);
    end
    cap = '0;
    for (int i = 0; i < 40; i++) begin
      cap = {cap[38:0], txd_b};
      @(negedge clk);
    end
    checks++;
    if (cap !== 40'h0F00000F0F) begin
      errors++; $display("[TB] FAIL narrow_wave: got %h expected 0f00000f0f", cap);
    end
    checks++;
    if (txd_b !== 1'b1 || count_b !== 5'd0) begin
      errors++; $display("[TB] FAIL narrow_idle: txd=%b count=%0d expected txd=1 count=0", txd_b, count_b);
    end
  endtask

  task automatic test_wide();
    logic [31:0] word;
    logic [7:0]  b;
    int          st;
    int          prev_st;
    bit          ok;
    word = 32'h44332211;
    prev_st = 0;
    do_reset();
    applyStimulus(1'b1, 1'b1, 1'b1, word, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (count_b !== 5'd4 || stall_b !== 1'b0) begin
      errors++; $display("[TB] FAIL wide_enq: count=%0d stall=%b expected count=4 stall=0", count_b, stall_b);
    end
    for (int j = 0; j < 4; j++) begin
      get_frame(0, b, st, ok);
      checks++;
      if (!ok || b !== word[8*j +: 8]) begin
        errors++; $display("[TB] FAIL wide_byte%0d: got %h ok=%0d expected %h", j, b, ok, word[8*j +: 8]);
      end
      if (j > 0) begin
        checks++;
        if (st - prev_st != 41) begin
          errors++; $display("[TB] FAIL wide_gap%0d: got %0d cycles expected 41", j, st - prev_st);
        end
      end
      prev_st = st;
    end
    checks++;
    if (count_b !== 5'd0) begin
      errors++; $display("[TB] FAIL wide_drained: count=%0d expected 0", count_b);
    end
  endtask

  task automatic test_mux();
    do_reset();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h12345678);
    #1;
    checks++;
    if (dtowrite_b !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL mux_mem: got %h expected deadbeef", dtowrite_b);
    end
    memtoreg = 1'b0;
    #1;
    checks++;
    if (dtowrite_b !== 32'h12345678) begin
      errors++; $display("[TB] FAIL mux_alu: got %h expected 12345678", dtowrite_b);
    end
    memtoreg = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (count_b !== 5'd0 || txd_b !== 1'b1) begin
      errors++; $display("[TB] FAIL mux_noenq: count=%0d txd=%b expected count=0 txd=1", count_b, txd_b);
    end
  endtask

  task automatic test_full_overflow();
    logic [7:0] exp_bytes [4];
    logic [7:0] b;
    int         st;
    bit         ok;
    exp_bytes[0] = 8'h3C;
    exp_bytes[1] = 8'h4B;
    exp_bytes[2] = 8'h5A;
    exp_bytes[3] = 8'hE7;
    do_reset();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h5A4B3C2D);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (count_s !== 3'd4 || stall_s !== 1'b1 || overflow_s !== 1'b0) begin
      errors++; $display("[TB] FAIL full_wide: count=%0d stall=%b ovf=%b expected 4/1/0", count_s, stall_s, overflow_s);
    end
    @(negedge clk);
    checks++;
    if (count_s !== 3'd3) begin
      errors++; $display("[TB] FAIL full_pop: count=%0d expected 3", count_s);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h000000E7);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (count_s !== 3'd4 || overflow_s !== 1'b0) begin
      errors++; $display("[TB] FAIL full_narrow: count=%0d ovf=%b expected 4/0", count_s, overflow_s);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h99999999);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (count_s !== 3'd4 || overflow_s !== 1'b1) begin
      errors++; $display("[TB] FAIL full_drop: count=%0d ovf=%b expected 4/1", count_s, overflow_s);
    end
    // Skip to the stop bit of the first frame, whose start was already seen.
    repeat (35) @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      get_frame(1, b, st, ok);
      checks++;
      if (!ok || b !== exp_bytes[j]) begin
        errors++; $display("[TB] FAIL wrap_byte%0d: got %h ok=%0d expected %h", j, b, ok, exp_bytes[j]);
      end
    end
    checks++;
    if (count_s !== 3'd0 || overflow_s !== 1'b1) begin
      errors++; $display("[TB] FAIL full_sticky: count=%0d ovf=%b expected 0/1", count_s, overflow_s);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_bytes [3];
    logic [7:0] b;
    int         st;
    bit         ok;
    exp_bytes[0] = 8'hA2;
    exp_bytes[1] = 8'hA3;
    exp_bytes[2] = 8'hA4;
    do_reset();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h000000A1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h000000A2);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h000000A3);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (count_b !== 5'd2) begin
      errors++; $display("[TB] FAIL simul_pre: count=%0d expected 2", count_b);
    end
    // The A1 frame popped 3 edges ago; the next pop is 41 edges after it.
    repeat (38) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h000000A4);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (count_b !== 5'd2 || txd_b !== 1'b0) begin
      errors++; $display("[TB] FAIL simul_count: count=%0d txd=%b expected count=2 txd=0", count_b, txd_b);
    end
    for (int j = 0; j < 3; j++) begin
      get_frame(0, b, st, ok);
      checks++;
      if (!ok || b !== exp_bytes[j]) begin
        errors++; $display("[TB] FAIL simul_byte%0d: got %h ok=%0d expected %h", j, b, ok, exp_bytes[j]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit quiet;
    do_reset();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0C0B0A09);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (count_b !== 5'd3 || txd_b !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_pre: count=%0d txd=%b expected 3/0", count_b, txd_b);
    end
    repeat (8) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (txd_b !== 1'b1 || count_b !== 5'd0 || overflow_b !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_state: txd=%b count=%0d ovf=%b expected 1/0/0", txd_b, count_b, overflow_b);
    end
    rstn = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (txd_b !== 1'b1 || count_b !== 5'd0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++; $display("[TB] FAIL midrst_quiet: activity=1 expected 0");
    end
  endtask

  initial begin
    rstn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_narrow();
    test_wide();
    test_mux();
    test_full_overflow();
    test_simultaneous();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
